// File: rtl/data_mem_responder.sv
// Data-memory responder for the RV32I core: one load/store at a time over
// valid/ready, little-endian word RAM, funct3 size/sign handling, wait states.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [CNT_W-1:0]  wait_cnt;

  logic              lat_write;
  logic              lat_err;
  logic [2:0]        lat_funct3;
  logic [1:0]        lat_off;
  logic [IDX_W-1:0]  lat_idx;
  logic [31:0]       lat_wdata;

  logic [31:0]       mem [DEPTH_WORDS];

  logic [ADDR_W-3:0] req_word;
  logic              accept;
  logic              funct3_ok;
  logic              align_ok;
  logic              range_ok;
  logic              req_ok;

  logic [3:0]        byte_en;
  logic [31:0]       wdata_lane;
  logic [31:0]       load_word;
  logic [31:0]       load_shift;
  logic [31:0]       load_ext;

  // Held low through reset so nothing is accepted before the responder is live.
  assign req_ready = rst_n && (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = req_valid && req_ready;
  assign req_word  = req_addr[ADDR_W-1:2];

  // Request legality: funct3 encoding, natural alignment and RAM range.
  // NOTE: every output of an always_comb gets a default first, so no path
  // can leave a signal unassigned and infer a latch.
  always_comb begin
    funct3_ok = 1'b0;
    align_ok  = 1'b1;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
      3'b100, 3'b101:         funct3_ok = !req_write;
      default:                funct3_ok = 1'b0;
    endcase
    case (req_funct3[1:0])
      SZ_HALF: align_ok = !req_addr[0];
      SZ_WORD: align_ok = (req_addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    range_ok = (req_word < DEPTH_LIM);
    req_ok   = funct3_ok && align_ok && range_ok;
  end

  // Rejected requests detour through ACCESS (with the RAM gated off) so an
  // error response appears one cycle after acceptance regardless of wait states.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!req_ok || (WAIT_STATES == 0)) state_nxt = ST_ACCESS;
          else                               state_nxt = ST_WAIT;
        end
      end
      ST_WAIT:   if (wait_cnt == '0) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   if (rsp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values and simulation matches the synthesized netlist.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      lat_write  <= 1'b0;
      lat_err    <= 1'b0;
      lat_funct3 <= 3'b000;
      lat_off    <= 2'b00;
      lat_idx    <= '0;
      lat_wdata  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wait_cnt   <= CNT_LOAD;
        lat_write  <= req_write;
        lat_err    <= !req_ok;
        lat_funct3 <= req_funct3;
        lat_off    <= req_addr[1:0];
        lat_idx    <= req_word[IDX_W-1:0];
        lat_wdata  <= req_wdata;
      end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
    end
  end

  // Little-endian lane steering for both directions.
  always_comb begin
    byte_en = 4'b1111;
    case (lat_funct3[1:0])
      SZ_BYTE: byte_en = 4'b0001 << lat_off;
      SZ_HALF: byte_en = 4'b0011 << lat_off;
      default: byte_en = 4'b1111;
    endcase
    wdata_lane = lat_wdata << {lat_off, 3'b000};
    load_word  = mem[lat_idx];
    load_shift = load_word >> {lat_off, 3'b000};
    load_ext   = load_word;
    case (lat_funct3)
      3'b000:  load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
      3'b001:  load_ext = {{16{load_shift[15]}}, load_shift[15:0]};
      3'b100:  load_ext = {24'h000000, load_shift[7:0]};
      3'b101:  load_ext = {16'h0000, load_shift[15:0]};
      default: load_ext = load_word;
    endcase
  end

  // NOTE: the RAM array has no reset; clearing it would cost a full sweep
  // and software never relies on power-up contents.
  always_ff @(posedge clk) begin
    if ((state == ST_ACCESS) && lat_write && !lat_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[lat_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

  // Response payload is captured on the ACCESS exit edge and then held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (state == ST_ACCESS) begin
      rsp_err   <= lat_err;
      rsp_rdata <= (lat_err || lat_write) ? 32'h0 : load_ext;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed steps plus random
// requests checked against a byte-array reference model.
module tb_data_mem_responder;

  localparam int WS0 = 1;
  localparam int WS1 = 3;

  logic        clk = 1'b0;
  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  logic [7:0]  mdl [2][4096];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS0), .ADDR_W(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS1), .ADDR_W(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-addressed memory with the architectural rules.
  task automatic model_op(input int sel, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic exp_err, output logic [31:0] exp_rd);
    int size;
    logic legal;
    logic [31:0] v;
    logic [31:0] mask;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (wr) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    legal = legal && ((addr % size) == 0) && ((addr / 4) < 1024);
    exp_err = !legal;
    exp_rd  = 32'h0;
    if (legal && wr) begin
      for (int k = 0; k < size; k++) mdl[sel][int'(addr) + k] = wd[8*k +: 8];
    end else if (legal) begin
      v = 32'h0;
      for (int k = 0; k < size; k++) v = v | (32'(mdl[sel][int'(addr) + k]) << (8 * k));
      mask = (size == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
      if (size < 4 && !f3[2] && v[8*size-1]) v = v | ~mask;
      exp_rd = v;
    end
  endtask

  // One full transaction: issue, time the response, optionally stall, hand off.
  task automatic do_req(input int sel, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int hold, input string tag, output logic [31:0] got);
    logic exp_err;
    logic [31:0] exp_rd;
    int n;
    int lat;
    int ws;
    logic ready_bad;
    logic stable_bad;
    logic [31:0] held_rd;
    logic held_err;
    ws = (sel == 0) ? WS0 : WS1;
    model_op(sel, wr, f3, addr, wd, exp_err, exp_rd);
    n = 0;
    while (req_ready[sel] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(req_ready[sel]), 32'd1);
    req_write[sel]  = wr;
    req_funct3[sel] = f3;
    req_addr[sel]   = addr;
    req_wdata[sel]  = wd;
    req_valid[sel]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[sel] = 1'b0;
    lat = 0;
    ready_bad = 1'b0;
    while (rsp_valid[sel] !== 1'b1 && lat < 40) begin
      if (req_ready[sel] !== 1'b0) ready_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), exp_err ? 32'd1 : 32'(1 + ws));
    check({tag, "_busy"}, 32'(ready_bad), 32'd0);
    check({tag, "_err"}, 32'(rsp_err[sel]), 32'(exp_err));
    check({tag, "_rdata"}, rsp_rdata[sel], exp_rd);
    got = rsp_rdata[sel];
    held_rd = rsp_rdata[sel];
    held_err = rsp_err[sel];
    stable_bad = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (rsp_valid[sel] !== 1'b1 || rsp_rdata[sel] !== held_rd ||
          rsp_err[sel] !== held_err || req_ready[sel] !== 1'b0) stable_bad = 1'b1;
    end
    if (hold > 0) check({tag, "_hold"}, 32'(stable_bad), 32'd0);
    rsp_ready[sel] = 1'b1;
    @(negedge clk);
    rsp_ready[sel] = 1'b0;
    check({tag, "_drop"}, 32'(rsp_valid[sel]), 32'd0);
    check({tag, "_idle"}, 32'(req_ready[sel]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          r;

    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b0;
      req_valid[s] = 1'b0;
      req_write[s] = 1'b0;
      req_funct3[s] = 3'b000;
      req_addr[s] = 32'h0;
      req_wdata[s] = 32'h0;
      rsp_ready[s] = 1'b0;
    end

    // Reset state
    #1;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst%0d_ready", s), 32'(req_ready[s]), 32'd0);
      check($sformatf("rst%0d_valid", s), 32'(rsp_valid[s]), 32'd0);
      check($sformatf("rst%0d_rdata", s), rsp_rdata[s], 32'h0);
      check($sformatf("rst%0d_err", s), 32'(rsp_err[s]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    check("post_rst_ready0", 32'(req_ready[0]), 32'd1);
    check("post_rst_ready1", 32'(req_ready[1]), 32'd1);

    // Word round trip
    do_req(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, "sw10", got);
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 0, "lw10", got);
    check("lw10_const", got, 32'hDEADBEEF);

    // Sub-word lanes
    do_req(0, 1'b1, 3'b010, 32'h20, 32'h00000000, 0, "sw20", got);
    do_req(0, 1'b1, 3'b000, 32'h22, 32'h000000F0, 0, "sb22", got);
    do_req(0, 1'b0, 3'b000, 32'h22, 32'h0, 0, "lb22", got);
    check("lb22_const", got, 32'hFFFFFFF0);
    do_req(0, 1'b0, 3'b100, 32'h22, 32'h0, 0, "lbu22", got);
    check("lbu22_const", got, 32'h000000F0);
    do_req(0, 1'b0, 3'b010, 32'h20, 32'h0, 0, "lw20", got);
    check("lw20_const", got, 32'h00F00000);

    // Errors
    do_req(0, 1'b0, 3'b001, 32'h21, 32'h0, 0, "lh21_misal", got);
    do_req(0, 1'b1, 3'b001, 32'h21, 32'hFFFF, 0, "sh21_misal", got);
    do_req(0, 1'b0, 3'b010, 32'h20, 32'h0, 0, "lw20_again", got);
    check("lw20_unchanged", got, 32'h00F00000);
    do_req(0, 1'b1, 3'b010, 32'h1000, 32'h11111111, 0, "sw1000_range", got);
    do_req(0, 1'b0, 3'b011, 32'h10, 32'h0, 0, "ld_f3_011", got);
    do_req(0, 1'b1, 3'b100, 32'h10, 32'h0, 0, "st_f3_100", got);
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 0, "lw10_after_err", got);
    check("lw10_after_err_const", got, 32'hDEADBEEF);

    // Half-word with sign at the upper half
    do_req(0, 1'b1, 3'b001, 32'h26, 32'hABCD8001, 0, "sh26", got);
    do_req(0, 1'b0, 3'b001, 32'h26, 32'h0, 0, "lh26", got);
    check("lh26_const", got, 32'hFFFF8001);
    do_req(0, 1'b0, 3'b101, 32'h26, 32'h0, 0, "lhu26", got);
    check("lhu26_const", got, 32'h00008001);

    // Backpressure
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 5, "bp_lw10", got);

    // Three wait states on the second instance
    do_req(1, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 0, "ws3_sw40", got);
    do_req(1, 1'b0, 3'b010, 32'h40, 32'h0, 2, "ws3_lw40", got);
    check("ws3_lw40_const", got, 32'hCAFEF00D);
    do_req(1, 1'b0, 3'b110, 32'h40, 32'h0, 0, "ws3_err", got);

    // Reset in the middle of a store
    do_req(0, 1'b1, 3'b010, 32'h30, 32'hAAAAAAAA, 0, "sw30_old", got);
    check("mid_rst_ready_pre", 32'(req_ready[0]), 32'd1);
    req_write[0]  = 1'b1;
    req_funct3[0] = 3'b010;
    req_addr[0]   = 32'h30;
    req_wdata[0]  = 32'h12345678;
    req_valid[0]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst_n[0] = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid[0]), 32'd0);
    check("mid_rst_ready", 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    check("mid_rst_idle", 32'(req_ready[0]), 32'd1);
    check("mid_rst_rdata", rsp_rdata[0], 32'h0);
    do_req(0, 1'b0, 3'b010, 32'h30, 32'h0, 0, "lw30", got);
    check("lw30_const", got, 32'hAAAAAAAA);

    // Random traffic against the model: initialise bytes 0..63 first
    for (int w = 0; w < 16; w++) begin
      do_req(0, 1'b1, 3'b010, 32'(4 * w), $urandom, 0, $sformatf("init%0d", w), got);
    end
    for (int i = 0; i < 50; i++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      r  = $urandom_range(0, 9);
      if (r == 0)      addr = 32'h1000 + 32'($urandom_range(0, 255));
      else if (r == 1) addr = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
      else             addr = 32'($urandom_range(0, 63));
      do_req(0, wr, f3, addr, $urandom, $urandom_range(0, 2), $sformatf("rnd%0d", i), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
